shmem_bank_ctrl: RTL
====================

Name: shmem_bank_ctrl

Overview:
- Controller for one shared-memory bank. Round-robin arbitrates load/store requests from all GPU cores, executes the winning access on a local storage array, and returns a one-hot completion pulse plus read data to the served core.
- Sixteen instances, one per bank, sit between the core array and the shared memory.
- The top level ORs the per-bank done vectors and routes rd_data to the core selected by grant_id.

Parameters:
N_CORES, 16, number of requesting cores
ADDR_W, 12, per-core address width
DATA_W, 8, data word width
BANK_BITS, 4, low address bits used as bank select; remaining ADDR_W-BANK_BITS bits index words inside the bank (256 words at default)

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
bank_n  input  BANK_BITS  static index of this bank
read  input  N_CORES  per-core load request, level, held until done
write  input  N_CORES  per-core store request, level, held until done
addr_in  input  N_CORES*ADDR_W  packed addresses, core i at [ADDR_W*i +: ADDR_W]
data_in  input  N_CORES*DATA_W  packed store data, core i at [DATA_W*i +: DATA_W]
done  output  N_CORES  one-hot, one-cycle completion pulse to the served core
rd_data  output  DATA_W  load result, valid while done is nonzero
grant_id  output  4  index of the core currently/last served
busy  output  1  high in ACCESS and RESP

Behaviour:
- Reset: the following are forced to their reset values.
  - FSM goes to IDLE.
  - done=0, rd_data=0, grant_id=0, busy=0.
  - RR pointer=0, mask register=0.
  - The storage array is not cleared.
- Reset mid-access aborts the access: no done pulse, and no write if the cycle is still ACCESS-pending.
- Eligibility: core i is eligible when (read[i] | write[i]) and addr_in_i[BANK_BITS-1:0]==bank_n and mask bit i is clear.
- FSM states:
  - IDLE: if any core is eligible, pick the first eligible index scanning ptr, ptr+1, ... wrapping mod N_CORES.
    - Latch id, op, word index and store data. op=write if write[id], else read; read and write both high is treated as a write.
    - grant_id<=id, go to ACCESS.
    - If no core is eligible, stay in IDLE.
    - Mask register clears on every IDLE cycle.
  - ACCESS: on a write, mem[word]<=latched data. On a read, rd_data<=mem[word]. Go to RESP.
  - RESP: done[id]=1 for exactly one cycle; rd_data holds its value. ptr<=(id+1) mod N_CORES; mask<=one-hot(id). Go to IDLE.
- Latency: request sampled in IDLE at cycle T, done at T+2; back-to-back grants every 3 cycles.
- Handshake: a requester drops its request in the cycle after done. The one-cycle mask guarantees the served core is not re-granted on its stale request.
- Inputs other than the latched fields are ignored while busy. A requester changing addr/data while waiting is legal until it is granted.
- Requests whose bank bits do not match bank_n are never served by this instance.
- Pointer wrap: id=15 sets ptr to 0.
- rd_data after a write access is unchanged from its previous value.
- All arithmetic is unsigned; the pointer increment wraps at 4 bits.
- Outputs are registered; there are no combinational input-to-output paths.

Test Plan:
- Single write then read, bank_n=3:
  - Core 5 writes addr 0x0A3 data 0x5C; expect done=0x0020 two cycles after the request.
  - Core 5 then reads 0x0A3; expect done=0x0020 with rd_data=0x5C.
- Contention, bank_n=3, ptr=0: cores 2, 7 and 12 all request addresses ending 0x3 simultaneously. Grants must occur in order 2, 7, 12, three cycles apart, with grant_id 2/7/12 and matching one-hot done.
- Fairness wrap:
  - After serving core 15, ptr=0.
  - Cores 15 and 1 then request; core 1 is served first.
  - A core 15 request held across its own done is not re-granted next cycle.
- Bank filter: core 4 reads addr 0x0A2 at bank_n=3. done stays 0 and busy stays 0 for 20 cycles.
- Read+write both high: core 9 asserts read and write at addr 0x013 with data 0xFF. A store occurs, so a later read returns 0xFF.
- Reset mid-op:
  - Assert reset in ACCESS of a core 6 write of 0x11 to a word holding 0x22.
  - Expect no done pulse and all outputs at 0.
  - A subsequent read returns 0x22.

Source files
------------

// File: rtl/shmem_bank_ctrl.sv
// shmem_bank_ctrl
//   Controller for one shared-memory bank. Load/store requests from all cores
//   are round-robin arbitrated. The winner's access runs on the bank's local
//   storage array, and the served core gets a one-cycle completion pulse plus
//   read data.
//   Each grant takes three cycles: IDLE (arbitrate) -> ACCESS (memory op) ->
//   RESP (done pulse). Grants can therefore be issued back to back every 3
//   cycles.
//
// Ports
//   clk       system clock, all logic on the rising edge
//   reset     synchronous active-high reset (storage array is not cleared)
//   bank_n    static index of this bank, compared against address low bits
//   read      per-core load request, level, held until done
//   write     per-core store request, level, held until done
//   addr_in   packed addresses, core i at [ADDR_W*i +: ADDR_W]
//   data_in   packed store data, core i at [DATA_W*i +: DATA_W]
//   done      one-hot, one-cycle completion pulse to the served core
//   rd_data   load result, valid while done is nonzero
//   grant_id  index of the core currently/last served
//   busy      high while an access is in flight (ACCESS and RESP)
module shmem_bank_ctrl #(
    parameter int N_CORES   = 16,
    parameter int ADDR_W    = 12,
    parameter int DATA_W    = 8,
    parameter int BANK_BITS = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [BANK_BITS-1:0]        bank_n,
    input  logic [N_CORES-1:0]          read,
    input  logic [N_CORES-1:0]          write,
    input  logic [N_CORES*ADDR_W-1:0]   addr_in,
    input  logic [N_CORES*DATA_W-1:0]   data_in,
    output logic [N_CORES-1:0]          done,
    output logic [DATA_W-1:0]           rd_data,
    output logic [3:0]                  grant_id,
    output logic                        busy
);

    localparam int ID_W   = 4;
    localparam int WORD_W = ADDR_W - BANK_BITS;
    localparam int WORDS  = 1 << WORD_W;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_RESP   = 2'd2;

    logic [1:0]          state;
    logic [ID_W-1:0]     ptr;
    logic [N_CORES-1:0]  mask;

    // Fields latched at grant time; later changes on the inputs are ignored.
    logic [ID_W-1:0]     id_q;
    logic                op_wr_q;
    logic [WORD_W-1:0]   word_q;
    logic [DATA_W-1:0]   wdata_q;

    logic [DATA_W-1:0]   mem [WORDS];

    logic [N_CORES-1:0]  elig;
    logic                found;
    logic [ID_W-1:0]     pick;
    logic [WORD_W-1:0]   pick_word;
    logic [DATA_W-1:0]   pick_data;

    function automatic logic [ID_W-1:0] wrap_inc(input logic [ID_W-1:0] v);
        if (int'(v) == N_CORES - 1)
            return '0;
        return v + 1'b1;
    endfunction

    function automatic logic [N_CORES-1:0] onehot(input logic [ID_W-1:0] v);
        logic [N_CORES-1:0] r;
        r    = '0;
        r[v] = 1'b1;
        return r;
    endfunction

    // The mask keeps the core served last out of the next arbitration. That
    // core may still hold its stale request during the IDLE cycle after done.
    always_comb begin
        for (int i = 0; i < N_CORES; i++)
            elig[i] = (read[i] | write[i])
                   && (addr_in[ADDR_W*i +: BANK_BITS] == bank_n)
                   && !mask[i];
    end

    // Scan from the highest offset down, so the last hit is the first
    // eligible core at or after ptr.
    always_comb begin
        logic [ID_W-1:0] idx;
        found = 1'b0;
        pick  = '0;
        idx   = '0;
        for (int k = N_CORES - 1; k >= 0; k--) begin
            idx = ID_W'((int'(ptr) + k) % N_CORES);
            if (elig[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    always_comb begin
        pick_word = '0;
        pick_data = '0;
        for (int i = 0; i < N_CORES; i++) begin
            if (ID_W'(i) == pick) begin
                pick_word = addr_in[ADDR_W*i + BANK_BITS +: WORD_W];
                pick_data = data_in[DATA_W*i +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            done     <= '0;
            rd_data  <= '0;
            grant_id <= '0;
            busy     <= 1'b0;
            ptr      <= '0;
            mask     <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    mask <= '0;
                    if (found) begin
                        grant_id <= pick;
                        busy     <= 1'b1;
                        state    <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    // A write leaves rd_data at its previous value.
                    if (!op_wr_q)
                        rd_data <= mem[word_q];
                    done  <= onehot(id_q);
                    state <= S_RESP;
                end
                S_RESP: begin
                    done  <= '0;
                    ptr   <= wrap_inc(id_q);
                    mask  <= onehot(id_q);
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // A request with both read and write set is executed as a store.
    always_ff @(posedge clk) begin
        if (state == S_IDLE && found) begin
            id_q    <= pick;
            op_wr_q <= write[pick];
            word_q  <= pick_word;
            wdata_q <= pick_data;
        end
    end

    // If reset lands during ACCESS, the pending store is dropped.
    always_ff @(posedge clk) begin
        if (!reset && state == S_ACCESS && op_wr_q)
            mem[word_q] <= wdata_q;
    end

endmodule
